// File: rtl/mismatch_checker_pkg.sv
// Shared definitions for the mismatch checker: checker FSM encoding and the
// deepest reference alignment the checker supports.
package mismatch_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAILED = 2'd2
  } state_e;

  localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/ref_delay_line.sv
// Fixed-depth shift register used to line up {valid, ref} with a pipelined
// component output. DEPTH=0 is a wire-through.
module ref_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_data = in_data;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // Reset clears the valid bit of every stage, so nothing in flight survives it.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign out_data = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mismatch_checker.sv
// Result checker: aligns reference/valid to the component output, flags
// mismatches, counts samples/errors, captures the first failure, and halts
// once the error budget is used up.
module mismatch_checker
  import mismatch_checker_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int LATENCY    = 0,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_ERRORS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] dut_data,
  input  logic [DATAWIDTH-1:0] ref_data,
  input  logic                 valid,
  input  logic                 clr,
  output logic                 err,
  output logic                 err_sticky,
  output logic                 halt,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] first_err_idx,
  output logic [DATAWIDTH-1:0] first_err_dut,
  output logic [DATAWIDTH-1:0] first_err_ref
);

  localparam int DEPTH = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  // One extra bit so a budget above the counter range can never be reached.
  localparam logic [CNT_WIDTH:0] MAX_ERR_W = (CNT_WIDTH + 1)'(MAX_ERRORS);

  logic [DATAWIDTH:0]   line_in;
  logic [DATAWIDTH:0]   line_out;
  logic                 valid_d;
  logic [DATAWIDTH-1:0] ref_d;
  logic                 mis;

  state_e               state_q, state_d;
  logic                 err_q, err_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0] error_cnt_q, error_cnt_d;
  logic [CNT_WIDTH-1:0] first_idx_q, first_idx_d;
  logic [DATAWIDTH-1:0] first_dut_q, first_dut_d;
  logic [DATAWIDTH-1:0] first_ref_q, first_ref_d;

  assign line_in = {valid, ref_data};

  ref_delay_line #(
    .WIDTH(DATAWIDTH + 1),
    .DEPTH(DEPTH)
  ) u_ref_delay_line (
    .clk     (clk),
    .rst     (rst),
    .in_data (line_in),
    .out_data(line_out)
  );

  assign valid_d = line_out[DATAWIDTH];
  assign ref_d   = line_out[DATAWIDTH-1:0];
  // Case inequality so an unknown component output is reported, not masked.
  assign mis     = valid_d & (dut_data !== ref_d);

  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    sticky_d     = sticky_q;
    sample_cnt_d = sample_cnt_q;
    error_cnt_d  = error_cnt_q;
    first_idx_d  = first_idx_q;
    first_dut_d  = first_dut_q;
    first_ref_d  = first_ref_q;

    if (clr) begin
      state_d      = ST_IDLE;
      sticky_d     = 1'b0;
      sample_cnt_d = '0;
      error_cnt_d  = '0;
      first_idx_d  = '0;
      first_dut_d  = '0;
      first_ref_d  = '0;
    end else if (state_q != ST_FAILED) begin
      err_d = mis;
      if (valid_d && !(&sample_cnt_q)) begin
        sample_cnt_d = sample_cnt_q + 1'b1;
      end
      if (mis && !(&error_cnt_q)) begin
        error_cnt_d = error_cnt_q + 1'b1;
      end
      if (mis && !sticky_q) begin
        sticky_d    = 1'b1;
        first_idx_d = sample_cnt_q;
        first_dut_d = dut_data;
        first_ref_d = ref_d;
      end
      // The sample that wakes the checker is judged in the same cycle, so a
      // first-sample mismatch can exhaust a budget of one straight from IDLE.
      if (valid_d) begin
        if (mis && ({1'b0, error_cnt_d} >= MAX_ERR_W)) begin
          state_d = ST_FAILED;
        end else begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      sticky_q     <= 1'b0;
      sample_cnt_q <= '0;
      error_cnt_q  <= '0;
      first_idx_q  <= '0;
      first_dut_q  <= '0;
      first_ref_q  <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      sticky_q     <= sticky_d;
      sample_cnt_q <= sample_cnt_d;
      error_cnt_q  <= error_cnt_d;
      first_idx_q  <= first_idx_d;
      first_dut_q  <= first_dut_d;
      first_ref_q  <= first_ref_d;
    end
  end

  assign err           = err_q;
  assign err_sticky    = sticky_q;
  assign halt          = (state_q == ST_FAILED);
  assign sample_count  = sample_cnt_q;
  assign error_count   = error_cnt_q;
  assign first_err_idx = first_idx_q;
  assign first_err_dut = first_dut_q;
  assign first_err_ref = first_ref_q;

endmodule

// File: tb/tb_mismatch_checker.sv
// Bench for mismatch_checker: five configurations share one stimulus bus; each
// scenario resets, drives its pattern and checks the instance it targets.
module tb_mismatch_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        valid;
  logic [31:0] ref_data;
  logic [31:0] dut_data;

  // u_a: LATENCY=0, MAX_ERRORS=4
  logic        err_a, sticky_a, halt_a;
  logic [31:0] scnt_a, ecnt_a, fidx_a, fdut_a, fref_a;
  // u_p3: LATENCY=3, MAX_ERRORS=4
  logic        err_p3, sticky_p3, halt_p3;
  logic [31:0] scnt_p3, ecnt_p3, fidx_p3, fdut_p3, fref_p3;
  // u_p2: LATENCY=2, MAX_ERRORS=1000
  logic        err_p2, sticky_p2, halt_p2;
  logic [31:0] scnt_p2, ecnt_p2, fidx_p2, fdut_p2, fref_p2;
  // u_h: LATENCY=0, MAX_ERRORS=2
  logic        err_h, sticky_h, halt_h;
  logic [31:0] scnt_h, ecnt_h, fidx_h, fdut_h, fref_h;
  // u_s: LATENCY=0, MAX_ERRORS=1, CNT_WIDTH=4
  logic        err_s, sticky_s, halt_s;
  logic [3:0]  scnt_s, ecnt_s, fidx_s;
  logic [31:0] fdut_s, fref_s;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  mismatch_checker #(.DATAWIDTH(32), .LATENCY(0), .CNT_WIDTH(32), .MAX_ERRORS(4)) u_a (
    .clk(clk), .rst(rst), .dut_data(dut_data), .ref_data(ref_data), .valid(valid), .clr(clr),
    .err(err_a), .err_sticky(sticky_a), .halt(halt_a), .sample_count(scnt_a),
    .error_count(ecnt_a), .first_err_idx(fidx_a), .first_err_dut(fdut_a), .first_err_ref(fref_a));

  mismatch_checker #(.DATAWIDTH(32), .LATENCY(3), .CNT_WIDTH(32), .MAX_ERRORS(4)) u_p3 (
    .clk(clk), .rst(rst), .dut_data(dut_data), .ref_data(ref_data), .valid(valid), .clr(clr),
    .err(err_p3), .err_sticky(sticky_p3), .halt(halt_p3), .sample_count(scnt_p3),
    .error_count(ecnt_p3), .first_err_idx(fidx_p3), .first_err_dut(fdut_p3), .first_err_ref(fref_p3));

  mismatch_checker #(.DATAWIDTH(32), .LATENCY(2), .CNT_WIDTH(32), .MAX_ERRORS(1000)) u_p2 (
    .clk(clk), .rst(rst), .dut_data(dut_data), .ref_data(ref_data), .valid(valid), .clr(clr),
    .err(err_p2), .err_sticky(sticky_p2), .halt(halt_p2), .sample_count(scnt_p2),
    .error_count(ecnt_p2), .first_err_idx(fidx_p2), .first_err_dut(fdut_p2), .first_err_ref(fref_p2));

  mismatch_checker #(.DATAWIDTH(32), .LATENCY(0), .CNT_WIDTH(32), .MAX_ERRORS(2)) u_h (
    .clk(clk), .rst(rst), .dut_data(dut_data), .ref_data(ref_data), .valid(valid), .clr(clr),
    .err(err_h), .err_sticky(sticky_h), .halt(halt_h), .sample_count(scnt_h),
    .error_count(ecnt_h), .first_err_idx(fidx_h), .first_err_dut(fdut_h), .first_err_ref(fref_h));

  mismatch_checker #(.DATAWIDTH(32), .LATENCY(0), .CNT_WIDTH(4), .MAX_ERRORS(1)) u_s (
    .clk(clk), .rst(rst), .dut_data(dut_data), .ref_data(ref_data), .valid(valid), .clr(clr),
    .err(err_s), .err_sticky(sticky_s), .halt(halt_s), .sample_count(scnt_s),
    .error_count(ecnt_s), .first_err_idx(fidx_s), .first_err_dut(fdut_s), .first_err_ref(fref_s));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    clr      = 1'b0;
    valid    = 1'b0;
    ref_data = '0;
    dut_data = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst      = 1'b1;
    clr      = 1'b1;
    valid    = 1'b1;
    ref_data = 32'h1234;
    dut_data = 32'h4321;
    tick();
    tick();
    n_checks++;
    if ({err_a, sticky_a, halt_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags_a: got %b expected 000", {err_a, sticky_a, halt_a});
    end
    n_checks++;
    if ({scnt_a, ecnt_a, fidx_a} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_counts_a: got %0h/%0h/%0h expected 0/0/0", scnt_a, ecnt_a, fidx_a);
    end
    n_checks++;
    if ({fdut_a, fref_a} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_capture_a: got %0h/%0h expected 0/0", fdut_a, fref_a);
    end
    n_checks++;
    if ({err_p3, sticky_p3, halt_p3, scnt_p3, ecnt_p3} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_p3: got err=%b halt=%b scnt=%0h ecnt=%0h expected all 0",
               err_p3, halt_p3, scnt_p3, ecnt_p3);
    end
    rst   = 1'b0;
    clr   = 1'b0;
    valid = 1'b0;
  endtask

  task automatic test_match();
    logic [31:0] exp_v;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      valid    = 1'b1;
      ref_data = 32'h0000_0005;
      dut_data = 32'h0000_0005;
      exp_q.push_back(32'd0);
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (err_a !== exp_v[0]) begin
        n_fail++;
        $display("FAIL match_err[%0d]: got %b expected %b", i, err_a, exp_v[0]);
      end
    end
    valid = 1'b0;
    n_checks++;
    if ({scnt_a, ecnt_a} !== {32'd10, 32'd0} || sticky_a !== 1'b0) begin
      n_fail++;
      $display("FAIL match_counts: got scnt=%0d ecnt=%0d sticky=%b expected 10/0/0",
               scnt_a, ecnt_a, sticky_a);
    end
  endtask

  task automatic test_single_mismatch();
    logic [31:0] exp_v;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      valid    = 1'b1;
      ref_data = (i == 3) ? 32'h8 : 32'h5;
      dut_data = (i == 3) ? 32'h7 : 32'h5;
      exp_q.push_back((i == 3) ? 32'd1 : 32'd0);
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (err_a !== exp_v[0]) begin
        n_fail++;
        $display("FAIL single_err[%0d]: got %b expected %b", i, err_a, exp_v[0]);
      end
    end
    valid = 1'b0;
    n_checks++;
    if ({fidx_a, fdut_a, fref_a} !== {32'd3, 32'h7, 32'h8}) begin
      n_fail++;
      $display("FAIL single_capture: got idx=%0d dut=%0h ref=%0h expected 3/7/8", fidx_a, fdut_a, fref_a);
    end
    n_checks++;
    if ({sticky_a, scnt_a, ecnt_a} !== {1'b1, 32'd6, 32'd1}) begin
      n_fail++;
      $display("FAIL single_counts: got sticky=%b scnt=%0d ecnt=%0d expected 1/6/1", sticky_a, scnt_a, ecnt_a);
    end
  endtask

  // A 3-stage registered pipe in the bench produces dut_data from ref_data.
  task automatic test_latency();
    logic [31:0] refs [20];
    logic [31:0] duts [20];
    logic        vals [20];
    logic [31:0] tmp;
    logic [31:0] exp_v;
    logic        e3, e2;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tmp     = $urandom_range(0, 16'hffff);
      refs[t] = {tmp[15:0], 16'(t + 1)};
      vals[t] = (t < 16);
      duts[t] = (t >= 3) ? refs[t-3] : 32'd0;
    end
    for (int t = 0; t < 20; t++) begin
      valid    = vals[t];
      ref_data = refs[t];
      dut_data = duts[t];
      e3 = (t >= 3) ? (vals[t-3] && (refs[t-3] !== duts[t])) : 1'b0;
      e2 = (t >= 2) ? (vals[t-2] && (refs[t-2] !== duts[t])) : 1'b0;
      exp_q.push_back({30'd0, e3, e2});
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({err_p3, err_p2} !== exp_v[1:0]) begin
        n_fail++;
        $display("FAIL latency_err[%0d]: got p3=%b p2=%b expected p3=%b p2=%b",
                 t, err_p3, err_p2, exp_v[1], exp_v[0]);
      end
    end
    valid = 1'b0;
    n_checks++;
    if ({scnt_p3, ecnt_p3} !== {32'd16, 32'd0}) begin
      n_fail++;
      $display("FAIL latency3_counts: got scnt=%0d ecnt=%0d expected 16/0", scnt_p3, ecnt_p3);
    end
    n_checks++;
    if ({scnt_p2, ecnt_p2} !== {32'd16, 32'd16}) begin
      n_fail++;
      $display("FAIL latency2_counts: got scnt=%0d ecnt=%0d expected 16/16", scnt_p2, ecnt_p2);
    end
    n_checks++;
    if ({fidx_p2, fdut_p2, fref_p2} !== {32'd0, 32'd0, refs[0]}) begin
      n_fail++;
      $display("FAIL latency2_capture: got idx=%0d dut=%0h ref=%0h expected 0/0/%0h",
               fidx_p2, fdut_p2, fref_p2, refs[0]);
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp_v;
    logic        halted = 1'b0;
    logic        e;
    int          errs   = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      valid    = 1'b1;
      ref_data = 32'h100 + i;
      dut_data = (i == 1 || i == 4) ? ((32'h100 + i) ^ 32'h1) : (32'h100 + i);
      e = 1'b0;
      if (!halted) begin
        e = (dut_data !== ref_data);
        if (e) errs++;
        if (errs >= 2) halted = 1'b1;
      end
      exp_q.push_back({30'd0, halted, e});
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({halt_h, err_h} !== exp_v[1:0]) begin
        n_fail++;
        $display("FAIL halt_seq[%0d]: got halt=%b err=%b expected halt=%b err=%b",
                 i, halt_h, err_h, exp_v[1], exp_v[0]);
      end
    end
    valid = 1'b0;
    n_checks++;
    if ({scnt_h, ecnt_h, fidx_h} !== {32'd5, 32'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL halt_counts: got scnt=%0d ecnt=%0d idx=%0d expected 5/2/1", scnt_h, ecnt_h, fidx_h);
    end
    n_checks++;
    if ({fdut_h, fref_h} !== {32'h100, 32'h101}) begin
      n_fail++;
      $display("FAIL halt_capture: got dut=%0h ref=%0h expected 100/101", fdut_h, fref_h);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] exp_v;
    logic [31:0] tmp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tmp      = $urandom;
      valid    = 1'b1;
      ref_data = tmp;
      dut_data = tmp;
      exp_q.push_back((i + 1 > 15) ? 32'd15 : 32'(i + 1));
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (scnt_s !== exp_v[3:0]) begin
        n_fail++;
        $display("FAIL saturate_cnt[%0d]: got %0d expected %0d", i, scnt_s, exp_v[3:0]);
      end
    end
    valid = 1'b0;
    n_checks++;
    if ({ecnt_s, halt_s, err_s} !== 6'd0) begin
      n_fail++;
      $display("FAIL saturate_clean: got ecnt=%0d halt=%b err=%b expected 0/0/0", ecnt_s, halt_s, err_s);
    end
  endtask

  task automatic test_clr_rst();
    logic [31:0] exp_v;
    do_reset();
    // Drive the LATENCY=3 checker into FAILED with four mismatches.
    for (int t = 0; t < 7; t++) begin
      valid    = 1'b1;
      ref_data = 32'hA000 + t;
      dut_data = 32'hDEAD_0000;
      exp_q.push_back((t >= 3) ? 32'd1 : 32'd0);
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (err_p3 !== exp_v[0]) begin
        n_fail++;
        $display("FAIL fail_err[%0d]: got %b expected %b", t, err_p3, exp_v[0]);
      end
    end
    n_checks++;
    if ({halt_p3, scnt_p3, ecnt_p3, fref_p3} !== {1'b1, 32'd4, 32'd4, 32'hA000}) begin
      n_fail++;
      $display("FAIL failed_state: got halt=%b scnt=%0d ecnt=%0d ref=%0h expected 1/4/4/a000",
               halt_p3, scnt_p3, ecnt_p3, fref_p3);
    end
    // clr while samples A004..A006 are still in the line.
    clr      = 1'b1;
    valid    = 1'b0;
    dut_data = 32'hA004;
    tick();
    n_checks++;
    if ({halt_p3, err_p3, sticky_p3, scnt_p3, ecnt_p3, fidx_p3, fref_p3} !== 131'd0) begin
      n_fail++;
      $display("FAIL clr_state: got halt=%b err=%b sticky=%b scnt=%0d ecnt=%0d expected all 0",
               halt_p3, err_p3, sticky_p3, scnt_p3, ecnt_p3);
    end
    clr      = 1'b0;
    dut_data = 32'hA005;
    tick();
    n_checks++;
    if ({err_p3, scnt_p3, ecnt_p3} !== {1'b0, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL clr_inflight_match: got err=%b scnt=%0d ecnt=%0d expected 0/1/0", err_p3, scnt_p3, ecnt_p3);
    end
    dut_data = 32'h0BAD;
    tick();
    n_checks++;
    if ({err_p3, scnt_p3, ecnt_p3, fidx_p3, fref_p3, fdut_p3} !== {1'b1, 32'd2, 32'd1, 32'd1, 32'hA006, 32'h0BAD}) begin
      n_fail++;
      $display("FAIL clr_inflight_mis: got err=%b scnt=%0d ecnt=%0d idx=%0d ref=%0h dut=%0h expected 1/2/1/1/a006/bad",
               err_p3, scnt_p3, ecnt_p3, fidx_p3, fref_p3, fdut_p3);
    end
    // Load three valid samples, then reset: none of them may be compared.
    for (int k = 0; k < 3; k++) begin
      valid    = 1'b1;
      ref_data = 32'hB0 + k;
      dut_data = 32'hB0 + k;
      tick();
    end
    n_checks++;
    if (scnt_p3 !== 32'd2) begin
      n_fail++;
      $display("FAIL preload_count: got %0d expected 2", scnt_p3);
    end
    rst      = 1'b1;
    valid    = 1'b0;
    dut_data = 32'h0BAD;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({err_p3, scnt_p3} !== 33'd0) begin
      n_fail++;
      $display("FAIL rst_edge: got err=%b scnt=%0d expected 0/0", err_p3, scnt_p3);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({err_p3, scnt_p3, ecnt_p3} !== 65'd0) begin
        n_fail++;
        $display("FAIL rst_flush[%0d]: got err=%b scnt=%0d ecnt=%0d expected 0/0/0", k, err_p3, scnt_p3, ecnt_p3);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_match();
    test_single_mismatch();
    test_latency();
    test_halt();
    test_saturate();
    test_clr_rst();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
